// File: rtl/piso16_tx.sv
// Parallel-in / serial-out transmitter with a one-word holding buffer so that
// back-to-back words stream without gaps. All outputs come straight from flops.
module piso16_tx #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             ld,
  output logic             ready,
  output logic             sout,
  output logic             sval,
  output logic             sfirst,
  output logic             slast
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_full;
  logic             r_ready;
  logic [CW-1:0]    r_cnt;
  logic             r_sfirst;
  logic             r_slast;

  logic             w_free;
  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    w_cnt_inc;

  assign w_free    = (r_state == IDLE) || r_slast;
  assign w_accept  = ld && r_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  // The output end of the shifter is fixed by the bit order; zeros fill in
  // behind, so the shifter is empty once a word has fully left.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_hold   <= '0;
      r_full   <= 1'b0;
      r_ready  <= 1'b1;
      r_cnt    <= '0;
      r_sfirst <= 1'b0;
      r_slast  <= 1'b0;
    end else if (w_free) begin
      // ready is low while a word is held, so r_full and w_accept never coincide.
      if (r_full || w_accept) begin
        r_shift  <= r_full ? r_hold : din;
        r_full   <= 1'b0;
        r_ready  <= 1'b1;
        r_state  <= SHIFT;
        r_cnt    <= '0;
        r_sfirst <= 1'b1;
        r_slast  <= 1'b0;
      end else begin
        r_state  <= IDLE;
        r_shift  <= '0;
        r_cnt    <= '0;
        r_sfirst <= 1'b0;
        r_slast  <= 1'b0;
      end
    end else begin
      r_shift  <= w_shifted;
      r_cnt    <= w_cnt_inc;
      r_sfirst <= 1'b0;
      r_slast  <= (w_cnt_inc == LAST_CNT);
      if (w_accept) begin
        r_hold  <= din;
        r_full  <= 1'b1;
        r_ready <= 1'b0;
      end
    end
  end

  assign ready  = r_ready;
  assign sout   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign sval   = (r_state == SHIFT);
  assign sfirst = r_sfirst;
  assign slast  = r_slast;

endmodule

// File: tb/tb_piso16_tx.sv
// Scoreboard bench for piso16_tx: three instances (16-bit MSB-first, 16-bit
// LSB-first, 8-bit MSB-first) checked against a word-level timing model.
module tb_piso16_tx;

  localparam int NCH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [NCH-1:0] ld;
  logic [NCH-1:0] ready;
  logic [NCH-1:0] sout;
  logic [NCH-1:0] sval;
  logic [NCH-1:0] sfirst;
  logic [NCH-1:0] slast;
  logic [31:0]    din [NCH];

  piso16_tx #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb16 (
    .clk(clk), .rst_n(rst_n), .din(din[0][15:0]), .ld(ld[0]), .ready(ready[0]),
    .sout(sout[0]), .sval(sval[0]), .sfirst(sfirst[0]), .slast(slast[0])
  );

  piso16_tx #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb16 (
    .clk(clk), .rst_n(rst_n), .din(din[1][15:0]), .ld(ld[1]), .ready(ready[1]),
    .sout(sout[1]), .sval(sval[1]), .sfirst(sfirst[1]), .slast(slast[1])
  );

  piso16_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
    .clk(clk), .rst_n(rst_n), .din(din[2][7:0]), .ld(ld[2]), .ready(ready[2]),
    .sout(sout[2]), .sval(sval[2]), .sfirst(sfirst[2]), .slast(slast[2])
  );

  typedef struct {
    int cyc;
    bit b;
    bit first;
    bit last;
  } exp_t;

  exp_t q [NCH][$];
  int   wid  [NCH] = '{16, 16, 8};
  bit   msbf [NCH] = '{1'b1, 1'b0, 1'b1};
  int   busy_until [NCH];
  int   hold_until [NCH];
  bit   exp_ready  [NCH];

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a word accepted in cycle c starts at c+1, or right after the word
  // ahead of it. If it has to wait, it sits in the holding buffer and ready is
  // low from c+1 until the cycle its first bit goes out.
  task automatic push_word(input int k, input int c, input logic [31:0] w);
    int start;
    exp_t e;
    start = (c + 1 > busy_until[k] + 1) ? c + 1 : busy_until[k] + 1;
    for (int i = 0; i < wid[k]; i++) begin
      e.cyc   = start + i;
      e.b     = msbf[k] ? w[wid[k]-1-i] : w[i];
      e.first = (i == 0);
      e.last  = (i == wid[k] - 1);
      q[k].push_back(e);
    end
    busy_until[k] = start + wid[k] - 1;
    if (start > c + 1) hold_until[k] = start - 1;
  endtask

  // Called at the start of a cycle once the inputs for it are driven.
  task automatic tick();
    int c;
    c = cyc;
    for (int k = 0; k < NCH; k++) begin
      exp_ready[k] = (c > hold_until[k]);
      if (!rst_n) begin
        while (q[k].size() > 0 && q[k][q[k].size()-1].cyc > c)
          void'(q[k].pop_back());
        busy_until[k] = -1;
        hold_until[k] = -1;
      end else if (ld[k] && exp_ready[k]) begin
        push_word(k, c, din[k]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] m_exp;
  logic [3:0] m_act;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < NCH; k++) begin
        m_exp = 4'b0000;
        if (q[k].size() > 0 && q[k][0].cyc == cyc) begin
          m_exp = {1'b1, q[k][0].b, q[k][0].first, q[k][0].last};
          void'(q[k].pop_front());
        end
        m_act = {sval[k], sout[k], sfirst[k], slast[k]};
        n_checks++;
        if (m_act !== m_exp) begin
          n_fail++;
          $display("FAIL serial ch%0d cyc %0d: sval/sout/sfirst/slast got %b want %b",
                   k, cyc, m_act, m_exp);
        end
        n_checks++;
        if (ready[k] !== exp_ready[k]) begin
          n_fail++;
          $display("FAIL ready ch%0d cyc %0d: got %b want %b", k, cyc, ready[k], exp_ready[k]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ld    = '0;
    for (int k = 0; k < NCH; k++) begin
      din[k]        = '0;
      busy_until[k] = -1;
      hold_until[k] = -1;
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // single words on every channel
    ld     = '1;
    din[0] = 32'h0000_A5C3;
    din[1] = 32'h0000_0001;
    din[2] = 32'h0000_0081;
    tick();
    ld = '0;
    repeat (20) tick();

    // back-to-back with ld held, then an overflow attempt while the buffer is full
    ld[0]  = 1'b1;
    din[0] = 32'h0000_FFFF;
    tick();
    din[0] = 32'h0000_0001;
    tick();
    din[0] = 32'h0000_1234;
    repeat (8) tick();
    ld[0] = 1'b0;
    repeat (40) tick();

    // reset after five bits of a word with another word held
    ld[0]  = 1'b1;
    din[0] = 32'h0000_F0F0;
    tick();
    din[0] = 32'h0000_5A5A;
    tick();
    ld[0] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();

    repeat (1500) begin
      for (int k = 0; k < NCH; k++) begin
        ld[k]  = ($urandom_range(0, 3) != 0);
        din[k] = $urandom;
      end
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    ld    = '0;
    repeat (40) tick();

    for (int k = 0; k < NCH; k++) begin
      n_checks++;
      if (q[k].size() != 0) begin
        n_fail++;
        $display("FAIL drain ch%0d: %0d expected bits never appeared, want 0", k, q[k].size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso16_tx.md
PISO16_TX -- requirements
Module: piso16_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning serial bit order (1 = bit WIDTH-1 first, 0 = bit 0 first).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port din, input, WIDTH bits: the parallel word to transmit.
REQ-006 The block SHALL have port ld, input, 1 bit: load request; din SHALL be sampled only on an edge where ld and ready are both high ("accept").
REQ-007 The block SHALL have port ready, output, 1 bit: high when the one-word holding buffer is empty.
REQ-008 The block SHALL have port sout, output, 1 bit: the serial data bit.
REQ-009 The block SHALL have port sval, output, 1 bit: high while sout carries a valid bit.
REQ-010 The block SHALL have port sfirst, output, 1 bit: high on the first bit of each word.
REQ-011 The block SHALL have port slast, output, 1 bit: high on the last bit of each word.
REQ-012 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-013 Storage: one WIDTH-bit shift register, one WIDTH-bit holding register with a full flag, and a bit counter cnt of ceil(log2(WIDTH)) bits.
REQ-014 Two-state FSM: IDLE (sval=0) and SHIFT (sval=1).
REQ-015 The shifter is "free" in a cycle when the state is IDLE, or the state is SHIFT with slast=1.
REQ-016 On an accept edge with the shifter free and the holding buffer empty, din SHALL load directly into the shifter; the first bit SHALL appear in the following cycle (one-cycle latency).
REQ-017 On an accept edge with the shifter not free, din SHALL load into the holding register, set the full flag, and ready SHALL go low in the following cycle.
REQ-018 On an edge where the shifter is free and the holding buffer is full, the holding word SHALL move into the shifter and the full flag SHALL clear; ready SHALL be high in the following cycle.
REQ-019 ready SHALL be low whenever the full flag is set, so an accept cannot coincide with the transfer in REQ-018.
REQ-020 A ld while ready is low SHALL be ignored: din is not sampled and no state changes.
REQ-021 On each shifter load, the block SHALL set state=SHIFT, cnt=0, sfirst=1.
REQ-022 On each edge in SHIFT, cnt SHALL increment and the shifter SHALL shift by one toward the output end.
REQ-023 sout SHALL equal shifter bit WIDTH-1 when MSB_FIRST=1, and bit 0 when MSB_FIRST=0.
REQ-024 slast SHALL be 1 exactly when cnt=WIDTH-1 in SHIFT; sfirst SHALL be 1 exactly when cnt=0 in SHIFT.
REQ-025 At the slast edge, with no accept and the holding buffer empty, the state SHALL return to IDLE; sval, sout, sfirst and slast SHALL be 0 in the following cycle.
REQ-026 Streaming: consecutive words SHALL be sent with no idle cycle between the last bit of one word and the first bit of the next.
REQ-027 In IDLE, sout SHALL be held at 0.
REQ-028 cnt SHALL never exceed WIDTH-1; there is no wrap-around within a word.

Reset
REQ-029 When rst_n is low at an edge, the next cycle SHALL show sout=0, sval=0, sfirst=0, slast=0, ready=1, state IDLE, cnt=0, full flag cleared.
REQ-030 Reset mid-word SHALL discard the word in the shifter and any held word; no remaining bits SHALL be emitted.
REQ-031 ld SHALL be ignored on any edge where rst_n is low.

Verification
REQ-032 Basic word (WIDTH=16, MSB_FIRST=1): after reset, ld=1 for one cycle with din=16'hA5C3 -> starting the next cycle, sval=1 for exactly 16 cycles with sout=1010_0101_1100_0011, sfirst on bit 1, slast on bit 16, then sval=0 and ready stays 1 throughout.
REQ-033 Back-to-back: ld held high with 16'hFFFF then 16'h0001 -> 32 contiguous valid bits (16 ones, then 15 zeros and a 1); ready is low from cycle 2 until the cycle after the first slast.
REQ-034 Overflow: while the holding buffer is full, present ld=1 with din=16'h1234 -> word ignored; only the two prior words are transmitted.
REQ-035 Reset mid-word: rst_n=0 for one edge after 5 bits of 16'hF0F0, with a held word pending -> next cycle sval=0 and ready=1; no further bits of either word appear.
REQ-036 LSB-first: MSB_FIRST=0, din=16'h0001 -> first bit 1, then 15 zeros.
REQ-037 Width: WIDTH=8, din=8'h81 -> 8 valid bits 1000_0001, with slast on the 8th bit.
